// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared constants and types for the I2C register sequencer.
// Holds the I2C core register map, CR command bytes, SR bit positions,
// and the sequencer state / byte-phase enumerations.
package i2c_seq_pkg;

  // I2C core register addresses (TXR/RXR and CR/SR share an address)
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  // CTR: core enable
  localparam logic [7:0] CTR_EN = 8'h80;

  // CR command bytes (STA=7, STO=6, RD=5, WR=4, ACK=3)
  localparam logic [7:0] CR_STA_WR     = 8'h90;
  localparam logic [7:0] CR_WR         = 8'h10;
  localparam logic [7:0] CR_WR_STO     = 8'h50;
  localparam logic [7:0] CR_RD_NAK_STO = 8'h68;
  localparam logic [7:0] CR_STO        = 8'h40;

  // SR bit positions
  localparam int SR_RXACK = 7;
  localparam int SR_TIP   = 1;

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_EN, IDLE, TX_W, CR_W, POLL, RX_R, STOP_W, STOP_POLL, DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_A, PH_R, PH_D, PH_RA, PH_RD
  } seq_phase_e;

  // Command byte issued to CR for each byte phase
  function automatic logic [7:0] cr_for_phase(input seq_phase_e ph);
    case (ph)
      PH_A:    return CR_STA_WR;
      PH_R:    return CR_WR;
      PH_D:    return CR_WR_STO;
      PH_RA:   return CR_STA_WR;
      PH_RD:   return CR_RD_NAK_STO;
      default: return CR_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_seq_wb_port.sv
// i2c_seq_wb_port: single-access WISHBONE master toward the I2C core.
// Latency: stb rises the cycle after go_i; done_o pulses the cycle after the ack.
// Backpressure: holds stb/adr/dat/we until m_ack_i; go_i is ignored while an access is open.
// Ports: go_i/adr_i/we_i/wdat_i start an access; done_o pulses once per completed
// access with rdat_o holding the captured read data; m_* is the core register bus.
module i2c_seq_wb_port (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       go_i,
  input  logic [2:0] adr_i,
  input  logic       we_i,
  input  logic [7:0] wdat_i,
  output logic       done_o,
  output logic [7:0] rdat_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  logic       stb_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       we_q;
  logic       done_q;
  logic [7:0] rdat_q;

  // stb drops in the cycle after ack, so a go arriving right after done
  // still leaves that cycle idle on the bus.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      stb_q  <= 1'b0;
      adr_q  <= 3'd0;
      dat_q  <= 8'h00;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      rdat_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (stb_q) begin
        if (m_ack_i) begin
          stb_q  <= 1'b0;
          done_q <= 1'b1;
          if (!we_q) rdat_q <= m_dat_i;
        end
      end else if (go_i) begin
        stb_q <= 1'b1;
        adr_q <= adr_i;
        dat_q <= wdat_i;
        we_q  <= we_i;
      end
    end
  end

  assign m_stb_o = stb_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_we_o  = we_q;
  assign done_o  = done_q;
  assign rdat_o  = rdat_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns single-register read/write requests into full I2C transactions.
// Latency: several bus accesses per byte phase, SR polled until TIP clears; rsp_valid pulses once.
// Backpressure: req_ready only in IDLE after init; one request in flight, req_valid ignored otherwise.
// Ports: req_* request channel, rsp_* one-cycle response, m_* register bus of the I2C core.
// Optional macro I2C_SEQ_TIMEOUT_EN bounds each SR poll loop to TIMEOUT_POLLS reads.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE      = 16'd99,
  parameter logic [15:0] TIMEOUT_POLLS = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic       m_ack_i
);

  seq_state_e state_q;
  seq_phase_e phase_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       busy_q;
  logic       go_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_nack_q;

  logic       wb_done;
  logic [7:0] wb_rdat;
  logic       acc_en;
  logic [2:0] acc_adr;
  logic       acc_we;
  logic [7:0] acc_dat;
  logic [7:0] txr_byte;

  // Byte loaded into TXR for the current phase
  always_comb begin
    txr_byte = 8'h00;
    case (phase_q)
      PH_A:    txr_byte = {dev_q, 1'b0};
      PH_R:    txr_byte = reg_q;
      PH_D:    txr_byte = wdata_q;
      PH_RA:   txr_byte = {dev_q, 1'b1};
      default: txr_byte = 8'h00;
    endcase
  end

  // Bus access owned by each state; these stay stable while the access is open
  always_comb begin
    acc_en  = 1'b1;
    acc_adr = ADR_SR;
    acc_we  = 1'b0;
    acc_dat = 8'h00;
    case (state_q)
      INIT_PL:   begin acc_adr = ADR_PRERLO; acc_we = 1'b1; acc_dat = PRESCALE[7:0];  end
      INIT_PH:   begin acc_adr = ADR_PRERHI; acc_we = 1'b1; acc_dat = PRESCALE[15:8]; end
      INIT_EN:   begin acc_adr = ADR_CTR;    acc_we = 1'b1; acc_dat = CTR_EN;         end
      TX_W:      begin acc_adr = ADR_TXR;    acc_we = 1'b1; acc_dat = txr_byte;       end
      CR_W:      begin acc_adr = ADR_CR;     acc_we = 1'b1; acc_dat = cr_for_phase(phase_q); end
      STOP_W:    begin acc_adr = ADR_CR;     acc_we = 1'b1; acc_dat = CR_STO;         end
      RX_R:      acc_adr = ADR_RXR;
      POLL, STOP_POLL: acc_adr = ADR_SR;
      default:   acc_en = 1'b0;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt_q;
  logic        rsp_timeout_q;
  logic        poll_expired;
  assign poll_expired = (poll_cnt_q + 16'd1) == TIMEOUT_POLLS;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_POLLS;
`endif

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= INIT_PL;
      phase_q     <= PH_A;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      busy_q      <= 1'b0;
      go_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt_q    <= 16'd0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      go_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      // Launch one access per state visit; busy_q blocks a relaunch until done
      if (acc_en && !busy_q) begin
        go_q   <= 1'b1;
        busy_q <= 1'b1;
      end
      if (wb_done) busy_q <= 1'b0;

      case (state_q)
        INIT_PL: if (wb_done) state_q <= INIT_PH;
        INIT_PH: if (wb_done) state_q <= INIT_EN;
        INIT_EN: if (wb_done) begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        IDLE: if (req_valid && req_ready_q) begin
          rw_q        <= req_rw;
          dev_q       <= req_dev;
          reg_q       <= req_reg;
          wdata_q     <= req_wdata;
          req_ready_q <= 1'b0;
          rsp_nack_q  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
          rsp_timeout_q <= 1'b0;
`endif
          phase_q     <= PH_A;
          state_q     <= TX_W;
        end
        TX_W: if (wb_done) state_q <= CR_W;
        CR_W: if (wb_done) begin
          state_q <= POLL;
`ifdef I2C_SEQ_TIMEOUT_EN
          poll_cnt_q <= 16'd0;
`endif
        end
        POLL: if (wb_done) begin
          if (wb_rdat[SR_TIP]) begin
`ifdef I2C_SEQ_TIMEOUT_EN
            if (poll_expired) begin
              rsp_timeout_q <= 1'b1;
              state_q       <= STOP_W;
            end else begin
              poll_cnt_q <= poll_cnt_q + 16'd1;
            end
`endif
          end else begin
            case (phase_q)
              PH_A: begin
                if (wb_rdat[SR_RXACK]) begin
                  rsp_nack_q <= 1'b1;
                  state_q    <= STOP_W;
                end else begin
                  phase_q <= PH_R;
                  state_q <= TX_W;
                end
              end
              PH_R: begin
                if (wb_rdat[SR_RXACK]) begin
                  rsp_nack_q <= 1'b1;
                  state_q    <= STOP_W;
                end else begin
                  phase_q <= rw_q ? PH_RA : PH_D;
                  state_q <= TX_W;
                end
              end
              PH_RA: begin
                if (wb_rdat[SR_RXACK]) begin
                  rsp_nack_q <= 1'b1;
                  state_q    <= STOP_W;
                end else begin
                  // RD has no TXR load; go straight to the command
                  phase_q <= PH_RD;
                  state_q <= CR_W;
                end
              end
              PH_D: begin
                // STOP already went out with the data byte's command
                rsp_nack_q  <= wb_rdat[SR_RXACK];
                rsp_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              default: state_q <= RX_R;
            endcase
          end
        end
        RX_R: if (wb_done) begin
          rsp_rdata_q <= wb_rdat;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        STOP_W: if (wb_done) begin
          state_q <= STOP_POLL;
`ifdef I2C_SEQ_TIMEOUT_EN
          poll_cnt_q <= 16'd0;
`endif
        end
        STOP_POLL: if (wb_done) begin
          if (!wb_rdat[SR_TIP]) begin
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (poll_expired) begin
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            poll_cnt_q <= poll_cnt_q + 16'd1;
          end
`endif
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  i2c_seq_wb_port u_wb_port (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .go_i     (go_q),
    .adr_i    (acc_adr),
    .we_i     (acc_we),
    .wdat_i   (acc_dat),
    .done_o   (wb_done),
    .rdat_o   (wb_rdat),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
`ifdef I2C_SEQ_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
